// File: rtl/lsu_pkg.sv
// Shared opcode/funct3 codes, FSM state type and store-lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} lsu_state_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_lanes_t;

  // size is funct3[1:0]: 00 byte, 01 half, anything else a full word
  function automatic store_lanes_t store_lanes(input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
    store_lanes_t s;
    case (size)
      2'b00: begin
        s.wstrb = 4'b0001 << off;
        s.wdata = {4{d[7:0]}};
      end
      2'b01: begin
        s.wstrb = off[1] ? 4'b1100 : 4'b0011;
        s.wdata = {2{d[15:0]}};
      end
      default: begin
        s.wstrb = 4'b1111;
        s.wdata = d;
      end
    endcase
    return s;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data aligner: picks the addressed byte/half out of the read word and extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    sel_b  = rdata[{off, 3'b000} +: 8];
    sel_h  = rdata[{off[1], 4'b0000} +: 16];
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{sel_b[7]}}, sel_b};
      F3_BU:   result = {24'd0, sel_b};
      F3_H:    result = {{16{sel_h[15]}}, sel_h};
      F3_HU:   result = {16'd0, sel_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: issues one data-memory request per load/store and writes loads back.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign instead.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_id,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd_id,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        bus_err
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic [4:0]    ld_rd;

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          is_load;
  logic          is_store;
  store_lanes_t  req_lanes;
  logic [31:0]   load_result;
  logic          unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign is_load           = (opcode == OPC_LOAD);
  assign is_store          = (opcode == OPC_STORE);
  assign req_lanes         = store_lanes(funct3[1:0], addr[1:0], store_data);
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign mem_req_valid = (state == REQ);

  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (ld_off),
    .funct3 (ld_f3),
    .result (load_result)
  );

  // NOTE: all state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
      ld_rd     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_rd_id  <= '0;
      wb_data   <= '0;
      bus_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign  <= 1'b0;
`endif
    end else begin
      wb_en   <= 1'b0;
      bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid && (is_load || is_store)) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(funct3[1:0], addr[1:0])) begin
              misalign <= 1'b1;
            end else begin
`else
            begin
`endif
              // Latch everything now; upstream is free to move on while we are busy.
              state     <= REQ;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= is_store ? req_lanes.wstrb : 4'b0000;
              mem_wdata <= is_store ? req_lanes.wdata : 32'd0;
              ld_f3     <= funct3;
              ld_off    <= addr[1:0];
              ld_rd     <= rd_id;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state <= mem_we ? IDLE : WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state    <= WB;
            wb_en    <= (ld_rd != 5'd0);
            wb_rd_id <= ld_rd;
            wb_data  <= load_result;
          end else if (TO_EN && (cnt == CNT_LAST)) begin
            state   <= IDLE;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WB: begin
          state    <= IDLE;
          wb_rd_id <= '0;
          wb_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed corner cases plus randomized loads/stores
// checked against an arithmetic reference model; the bench itself plays the data memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_id;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd_id;
  logic [31:0] wb_data;
  logic        busy;
  logic        bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .instr         (instr),
    .addr          (addr),
    .store_data    (store_data),
    .rd_id         (rd_id),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .wb_en         (wb_en),
    .wb_rd_id      (wb_rd_id),
    .wb_data       (wb_data),
    .busy          (busy),
    .bus_err       (bus_err)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the byte offset, not bit slicing.
  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] bv;
    logic [31:0] hv;
    bv = (rdata >> (8 * (a % 4))) % 256;
    hv = (rdata >> (16 * ((a / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
      3'd4:    return bv;
      3'd1:    return (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
      3'd5:    return hv;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] exp_wstrb(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'd0:    return 32'd1 << (a % 4);
      3'd1:    return ((a / 2) % 2 == 1) ? 32'd12 : 32'd3;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic bit exp_misaligned(input logic [31:0] a, input logic [2:0] f3);
    return ((f3 % 4 == 1) && (a % 2 == 1)) || ((f3 % 4 == 2) && (a % 4 != 0));
  endfunction

  // One full transaction; the bench acts as memory with the given request stall and response delay.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int stall, input int dly,
                        output logic [31:0] obs_wb, output logic [31:0] obs_wdata,
                        output logic [3:0] obs_wstrb);
    logic [31:0] e_addr;
    obs_wb    = '0;
    obs_wdata = '0;
    obs_wstrb = '0;
    e_addr    = (a / 4) * 4;
    @(negedge clk);
    req_valid  = 1'b1;
    instr      = {7'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom),
                  (st ? OPC_STORE : OPC_LOAD)};
    addr       = a;
    store_data = sd;
    rd_id      = rd;
    check("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid  = 1'b0;
    instr      = $urandom;
    addr       = $urandom;
    store_data = $urandom;
    rd_id      = 5'($urandom);
`ifdef LSU_MISALIGN_TRAP_EN
    if (exp_misaligned(a, f3)) begin
      check("misalign_pulse", misalign, 1);
      check("misalign_no_req", mem_req_valid, 0);
      check("misalign_idle", busy, 0);
      @(negedge clk);
      check("misalign_one_cycle", misalign, 0);
      check("misalign_no_wb", wb_en, 0);
      return;
    end
`endif
    check("req_valid", mem_req_valid, 1);
    check("req_busy", busy, 1);
    check("req_not_ready", req_ready, 0);
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, st);
    check("mem_wstrb", mem_wstrb, st ? exp_wstrb(a, f3) : 32'd0);
    if (st) check("mem_wdata", mem_wdata, exp_wdata(sd, f3));
    obs_wdata = mem_wdata;
    obs_wstrb = mem_wstrb;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", mem_req_valid, 1);
      check("stall_addr", mem_addr, e_addr);
      check("stall_wdata", mem_wdata, obs_wdata);
      check("stall_busy", busy, 1);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_dropped", mem_req_valid, 0);
    if (st) begin
      check("store_done", busy, 0);
      check("store_no_wb", wb_en, 0);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      check("wait_busy", busy, 1);
      check("wait_no_wb", wb_en, 0);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rdata     = $urandom;
    check("wb_en", wb_en, (rd != 0));
    check("wb_rd_id", wb_rd_id, rd);
    if (rd != 0) check("wb_data", wb_data, exp_load(rdata, a, f3));
    obs_wb = wb_data;
    @(negedge clk);
    check("wb_one_cycle", wb_en, 0);
    check("back_idle", busy, 0);
  endtask

  // Start a load and finish the request handshake, leaving the DUT in WAIT.
  task automatic load_to_wait(input logic [31:0] a, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1;
    instr     = {17'd0, F3_W, 5'd0, OPC_LOAD};
    addr      = a;
    rd_id     = rd;
    @(negedge clk);
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("in_wait_busy", busy, 1);
  endtask

  logic [31:0] got_wb;
  logic [31:0] got_wdata;
  logic [3:0]  got_wstrb;

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    instr         = '0;
    addr          = '0;
    store_data    = '0;
    rd_id         = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_wb_data", wb_data, 0);
    rst = 1'b0;

    // lw with immediate ready/response: wb lands three cycles after accept
    access(1'b0, F3_W, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, got_wb, got_wdata, got_wstrb);
    check("lw_const", got_wb, 32'hDEADBEEF);
    access(1'b0, F3_B, 32'h103, 32'h0, 5'd9, 32'h80FF0000, 0, 0, got_wb, got_wdata, got_wstrb);
    check("lb_const", got_wb, 32'hFFFFFF80);
    access(1'b0, F3_BU, 32'h103, 32'h0, 5'd9, 32'h80FF0000, 0, 0, got_wb, got_wdata, got_wstrb);
    check("lbu_const", got_wb, 32'h00000080);
    access(1'b1, F3_H, 32'h202, 32'h1234ABCD, 5'd3, 32'h0, 0, 0, got_wb, got_wdata, got_wstrb);
    check("sh_wdata_const", got_wdata, 32'hABCDABCD);
    check("sh_wstrb_const", got_wstrb, 4'b1100);
    // stalled request, then a load to x0
    access(1'b0, F3_W, 32'h300, 32'h0, 5'd0, 32'h55AA55AA, 3, 1, got_wb, got_wdata, got_wstrb);

    // timeout: no response, bus_err four cycles into WAIT, late response ignored
    load_to_wait(32'h40, 5'd7);
    check("to_no_err_0", bus_err, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("to_no_err", bus_err, 0);
      check("to_still_busy", busy, 1);
    end
    @(negedge clk);
    check("to_bus_err", bus_err, 1);
    check("to_idle", busy, 0);
    check("to_no_wb", wb_en, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("to_err_one_cycle", bus_err, 0);
    check("to_late_rsp_no_wb", wb_en, 0);
    check("to_late_rsp_idle", busy, 0);

    // stale response while idle and a non-memory opcode are both ignored
    mem_rsp_valid = 1'b1;
    req_valid     = 1'b1;
    instr         = {17'd0, 3'd0, 5'd1, 7'b0110011};
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    req_valid     = 1'b0;
    check("alu_op_ignored", busy, 0);
    check("alu_op_no_req", mem_req_valid, 0);
    check("idle_rsp_no_wb", wb_en, 0);

    // reset while waiting abandons the access
    load_to_wait(32'h80, 5'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait_idle", busy, 0);
    check("rst_wait_ready", req_ready, 1);
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rst_wait_no_wb", wb_en, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    access(1'b0, F3_W, 32'h102, 32'h0, 5'd6, 32'h0, 0, 0, got_wb, got_wdata, got_wstrb);
`endif

    // randomized loads and stores
    for (int n = 0; n < 60; n++) begin
      bit          st;
      logic [2:0]  f3;
      st = bit'($urandom_range(0, 1));
      if (st) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = F3_B;
          1:       f3 = F3_H;
          2:       f3 = F3_W;
          3:       f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
      end
      access(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), got_wb, got_wdata, got_wstrb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
